// File: rtl/pipe_stage_skid_if.sv
// Purpose : handshake/payload bundle between a pipeline stage and its neighbours.
// Latency : n/a (signal bundle only).
// Backpressure: carries in_ready_o upstream and out_ready_i downstream.
// Ports (slave = stage side):
//   in_valid_i/in_ready_o/in_data_i    upstream beat
//   hold_i, flush_i                    hazard hold, branch flush
//   out_valid_o/out_ready_i/out_data_o downstream beat
//   stall_cnt_o, flush_cnt_o           saturating event counters
interface pipe_stage_skid_if #(
  parameter int DATA_W = 76,
  parameter int CNT_W  = 16
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              hold_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport slave (
    input  in_valid_i, in_data_i, hold_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output in_valid_i, in_data_i, hold_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Purpose : generic pipeline stage register with optional 2-entry skid, hold, flush and stall/flush counters.
// Latency : 1 cycle in->out when empty; 1 beat/cycle sustained with out_ready_i=1.
// Backpressure: SKID=1 -> in_ready_o from skid occupancy only; SKID=0 -> ready passes through from out_ready_i.
// Ports:
//   CLK, nRESET   clock (rising edge), synchronous active-low reset
//   bus (slave)   in_valid_i/in_ready_o/in_data_i, hold_i, flush_i,
//                 out_valid_o/out_ready_i/out_data_o, stall_cnt_o, flush_cnt_o
module pipe_stage_skid #(
  parameter int                DATA_W   = 76,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter bit                SKID     = 1'b1,
  parameter int                CNT_W    = 16
) (
  input logic              CLK,
  input logic              nRESET,
  pipe_stage_skid_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_main_v;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_in_ready;
  logic w_out_fire;
  logic w_in_fire;
  logic w_stall_inc;
  logic w_flush_hit;

  // Flush forces ready high so the upstream beat is consumed and dropped
  // rather than left waiting behind a killed stage.
  always_comb begin
    w_in_ready = 1'b0;
    if (bus.flush_i)
      w_in_ready = 1'b1;
    else if (bus.hold_i)
      w_in_ready = 1'b0;
    else if (SKID)
      w_in_ready = ~r_skid_v;
    else
      w_in_ready = ~r_main_v | bus.out_ready_i;
  end

  assign w_out_fire  = r_main_v & bus.out_ready_i & ~bus.hold_i;
  assign w_in_fire   = bus.in_valid_i & w_in_ready & ~bus.flush_i;
  assign w_stall_inc = r_main_v & ~w_out_fire & ~bus.flush_i;
  assign w_flush_hit = bus.flush_i & (r_main_v | r_skid_v);

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_main_v    <= 1'b0;
      r_main_data <= NOP_DATA;
      r_skid_v    <= 1'b0;
      r_skid_data <= NOP_DATA;
    end else if (bus.flush_i) begin
      r_main_v    <= 1'b0;
      r_main_data <= NOP_DATA;
      r_skid_v    <= 1'b0;
      r_skid_data <= NOP_DATA;
    end else if (!bus.hold_i) begin
      if (SKID) begin
        if (!r_main_v) begin
          // Skid is always empty while main is empty.
          if (w_in_fire) begin
            r_main_v    <= 1'b1;
            r_main_data <= bus.in_data_i;
          end else begin
            r_main_data <= NOP_DATA;
          end
        end else if (w_out_fire) begin
          if (r_skid_v) begin
            // Oldest waiting beat moves up; in_ready was low, so no new beat here.
            r_main_data <= r_skid_data;
            r_skid_v    <= w_in_fire;
            if (w_in_fire)
              r_skid_data <= bus.in_data_i;
          end else if (w_in_fire) begin
            r_main_data <= bus.in_data_i;
          end else begin
            r_main_v    <= 1'b0;
            r_main_data <= NOP_DATA;
          end
        end else if (w_in_fire) begin
          // Main is stalled: park the accepted beat in the skid slot.
          r_skid_v    <= 1'b1;
          r_skid_data <= bus.in_data_i;
        end
      end else begin
        if (w_out_fire || !r_main_v) begin
          r_main_v    <= w_in_fire;
          r_main_data <= w_in_fire ? bus.in_data_i : NOP_DATA;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_hit && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_main_v;
  assign bus.out_data_o  = r_main_data;
  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;

endmodule
